jk_ff_bank: RTL

- Parametrised, multi-channel successor to the single-bit JK flip-flop: WIDTH independent JK channels sharing one clock, an enable and an asynchronous active-low reset.
- Adds parallel load, a configurable J=K=1 behaviour, registered per-bit rise/fall pulses and a saturating change counter.
- Sits in control/status logic wherever banks of set/reset/toggle flags are needed, e.g. mode flags, sticky status bits and handshake latches.

---
 rtl/jk_pkg.sv | 24 ++
 rtl/jk_cell.sv | 28 ++
 rtl/jk_ff_bank.sv | 68 ++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types and the per-bit JK next-state rule for the jk_ff_bank family.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_op_t;

   // J=K=1 either toggles or holds, chosen at elaboration time by toggle_en.
   function automatic logic jk_next(input logic q, input jk_op_t op, input logic toggle_en);
      logic r;
      case (op)
         JK_HOLD: r = q;
         JK_RST:  r = 1'b0;
         JK_SET:  r = 1'b1;
         JK_TGL:  r = toggle_en ? ~q : q;
         default: r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One-bit combinational next-state helper: load beats enable, enable gates the JK rule.
module jk_cell
   import jk_pkg::*;
#(
   parameter bit TOGGLE_EN = 1'b1
) (
   input  logic q,
   input  logic j,
   input  logic k,
   input  logic en,
   input  logic load,
   input  logic load_val,
   output logic q_n
);

   jk_op_t op;

   always_comb begin
      op = jk_op_t'({j, k});
      if (load)
         q_n = load_val;
      else if (!en)
         q_n = q;
      else
         q_n = jk_next(q, op, TOGGLE_EN);
   end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops with parallel load, registered edge pulses and a
// saturating counter of edges on which any bit changed.
module jk_ff_bank
   import jk_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               TOGGLE_EN = 1'b1,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall,
   output logic [CNT_W-1:0] chg_cnt,
   output logic             cnt_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] q_n;
   logic [CNT_W-1:0] cnt_n;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell #(.TOGGLE_EN(TOGGLE_EN)) u_cell (
         .q        (q[i]),
         .j        (j[i]),
         .k        (k[i]),
         .en       (en),
         .load     (load),
         .load_val (load_val[i]),
         .q_n      (q_n[i])
      );
   end

   // Clear wins over a simultaneous change; the count never wraps.
   always_comb begin
      cnt_n = chg_cnt;
      if (cnt_clr)
         cnt_n = '0;
      else if ((q_n != q) && (chg_cnt != CNT_MAX))
         cnt_n = chg_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q       <= RESET_VAL;
         q_rise  <= '0;
         q_fall  <= '0;
         chg_cnt <= '0;
         cnt_sat <= 1'b0;
      end else begin
         q       <= q_n;
         q_rise  <= q_n & ~q;
         q_fall  <= ~q_n & q;
         chg_cnt <= cnt_n;
         cnt_sat <= (cnt_n == CNT_MAX);
      end
   end

endmodule
